// File: rtl/alu_exec_unit.sv
// Registered MIPS execute stage: ALU control decode, ALU, zero flag and branch gate.
// Optional signed add/sub overflow output is enabled by defining ALU_OVF_EN.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             branch,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
`ifdef ALU_OVF_EN
  output logic             overflow,
`endif
  output logic             branch_taken
);

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100
  } ctrl_e;

  ctrl_e            w_ctrl;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_lt;
  logic             w_zero;

  always_comb begin
    w_ctrl = CTRL_ADD;
    case (alu_op)
      2'b00: w_ctrl = CTRL_ADD;
      2'b01: w_ctrl = CTRL_SUB;
      2'b11: w_ctrl = CTRL_OR;
      default: begin
        case (funct)
          6'b100000: w_ctrl = CTRL_ADD;
          6'b100010: w_ctrl = CTRL_SUB;
          6'b100100: w_ctrl = CTRL_AND;
          6'b100101: w_ctrl = CTRL_OR;
          6'b101010: w_ctrl = CTRL_SLT;
          6'b100111: w_ctrl = CTRL_NOR;
          default:   w_ctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  // Signed compare directly, so slt stays correct when a-b overflows.
  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt   = $signed(a) < $signed(b);

  always_comb begin
    w_result = '0;
    case (w_ctrl)
      CTRL_AND: w_result = a & b;
      CTRL_OR:  w_result = a | b;
      CTRL_ADD: w_result = w_sum;
      CTRL_SUB: w_result = w_diff;
      CTRL_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      CTRL_NOR: w_result = ~(a | b);
      default:  w_result = '0;
    endcase
  end

  assign w_zero = (w_result == '0);

`ifdef ALU_OVF_EN
  logic w_ovf;

  // Overflow when same-sign addends (or opposite-sign sub operands) yield a result whose sign differs from a.
  always_comb begin
    w_ovf = 1'b0;
    case (w_ctrl)
      CTRL_ADD: w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      CTRL_SUB: w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      default:  w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= w_ovf;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl     <= 4'b0000;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      alu_ctrl     <= w_ctrl;
      result       <= w_result;
      zero         <= w_zero;
      branch_taken <= branch & w_zero;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, a monitor pops and compares.
// Overflow checks are active when ALU_OVF_EN is defined.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
`ifdef ALU_OVF_EN
  logic        overflow;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op       (alu_op),
    .funct        (funct),
    .a            (a),
    .b            (b),
    .branch       (branch),
    .alu_ctrl     (alu_ctrl),
    .result       (result),
    .zero         (zero),
`ifdef ALU_OVF_EN
    .overflow     (overflow),
`endif
    .branch_taken (branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        bt;
    logic        ovf;
  } exp_t;

  exp_t expQ[$];
  int   issuedCnt = 0;
  int   launchedCnt = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, req);
    end
  endtask

  // Issue one vector on the falling edge; zero and branch_taken expectations follow from the hand-computed result.
  task automatic applyStimulus(input logic rstV, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] av, input logic [31:0] bv, input logic br,
                               input logic [3:0] eCtrl, input logic [31:0] eRes, input logic eOvf);
    exp_t e;
    @(negedge clk);
    rst = rstV; alu_op = op; funct = fn; a = av; b = bv; branch = br;
    e.idx  = issuedCnt;
    e.ctrl = rstV ? 4'b0000 : eCtrl;
    e.res  = rstV ? 32'h0 : eRes;
    e.z    = !rstV && (e.res == 32'h0);
    e.bt   = br && e.z;
    e.ovf  = rstV ? 1'b0 : eOvf;
    expQ.push_back(e);
    issuedCnt++;
  endtask

  // Monitor: every edge that sampled an issued vector yields one registered output set.
  always @(posedge clk) begin
    exp_t e;
    if (issuedCnt != launchedCnt) begin
      launchedCnt = issuedCnt;
      #1;
      if (expQ.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL scoreboard: got output with empty queue, expected entry");
      end else begin
        e = expQ.pop_front();
        checkOutput("alu_ctrl", e.idx, {28'h0, alu_ctrl}, {28'h0, e.ctrl});
        checkOutput("result", e.idx, result, e.res);
        checkOutput("zero", e.idx, {31'h0, zero}, {31'h0, e.z});
        checkOutput("branch_taken", e.idx, {31'h0, branch_taken}, {31'h0, e.bt});
`ifdef ALU_OVF_EN
        checkOutput("overflow", e.idx, {31'h0, overflow}, {31'h0, e.ovf});
`endif
      end
    end
  end

  initial begin
    int waitCycles;
    rst = 1'b1; alu_op = 2'b01; funct = 6'h0; a = 32'd5; b = 32'd5; branch = 1'b1;

    // Reset held two edges, then released with the same beq-style inputs.
    applyStimulus(1, 2'b01, 6'h00, 32'd5, 32'd5, 1, 4'h0, 32'h0, 0);
    applyStimulus(1, 2'b01, 6'h00, 32'd5, 32'd5, 1, 4'h0, 32'h0, 0);
    applyStimulus(0, 2'b01, 6'h00, 32'd5, 32'd5, 1, 4'b0110, 32'h0, 0);

    // R-type sweep with a=12, b=10.
    applyStimulus(0, 2'b10, 6'b100000, 32'hC, 32'hA, 0, 4'b0010, 32'h16, 0);
    applyStimulus(0, 2'b10, 6'b100010, 32'hC, 32'hA, 0, 4'b0110, 32'h2, 0);
    applyStimulus(0, 2'b10, 6'b100100, 32'hC, 32'hA, 0, 4'b0000, 32'h8, 0);
    applyStimulus(0, 2'b10, 6'b100101, 32'hC, 32'hA, 0, 4'b0001, 32'hE, 0);
    applyStimulus(0, 2'b10, 6'b101010, 32'hC, 32'hA, 0, 4'b0111, 32'h0, 0);
    applyStimulus(0, 2'b10, 6'b100111, 32'hC, 32'hA, 0, 4'b1100, 32'hFFFFFFF1, 0);

    // Branch gating.
    applyStimulus(0, 2'b01, 6'h00, 32'h1234, 32'h1234, 1, 4'b0110, 32'h0, 0);
    applyStimulus(0, 2'b01, 6'h00, 32'h1234, 32'h1235, 1, 4'b0110, 32'hFFFFFFFF, 0);
    applyStimulus(0, 2'b01, 6'h00, 32'h1234, 32'h1234, 0, 4'b0110, 32'h0, 0);

    // Signed slt edges.
    applyStimulus(0, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 0, 4'b0111, 32'h1, 0);
    applyStimulus(0, 2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 0, 4'b0111, 32'h0, 0);
    applyStimulus(0, 2'b10, 6'b101010, 32'h3, 32'h3, 0, 4'b0111, 32'h0, 0);

    // Wrap-around and default decode.
    applyStimulus(0, 2'b00, 6'h00, 32'hFFFFFFFF, 32'h1, 1, 4'b0010, 32'h0, 0);
    applyStimulus(0, 2'b10, 6'b001000, 32'h3, 32'h4, 0, 4'b0010, 32'h7, 0);
    applyStimulus(0, 2'b11, 6'h00, 32'hF0, 32'h0F, 0, 4'b0001, 32'hFF, 0);

    // Reset mid-stream discards the in-flight op; first post-reset result follows.
    applyStimulus(0, 2'b00, 6'h00, 32'h3, 32'h4, 0, 4'b0010, 32'h7, 0);
    applyStimulus(1, 2'b00, 6'h00, 32'h9, 32'h9, 1, 4'h0, 32'h0, 0);
    applyStimulus(0, 2'b01, 6'h00, 32'h9, 32'h9, 1, 4'b0110, 32'h0, 0);

    // Signed overflow cases.
    applyStimulus(0, 2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 0, 4'b0010, 32'h80000000, 1);
    applyStimulus(0, 2'b01, 6'h00, 32'h80000000, 32'h1, 0, 4'b0110, 32'h7FFFFFFF, 1);
    applyStimulus(0, 2'b00, 6'h00, 32'h1, 32'h1, 0, 4'b0010, 32'h2, 0);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage block of the single-cycle MIPS datapath; merges ALU control decode, ALU and branch AND gate into one registered unit.
- Decodes the 2-bit main-control ALU opcode plus instruction funct into a 4-bit ALU operation.
- Computes the result and zero flag, and forms branch_taken = branch AND zero for the PC-source mux.
- All outputs are registered on clk (1-cycle latency).

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_op  in  2  ALUOpcode from main control
- funct  in  6  instruction[5:0]
- a  in  WIDTH  operand A (readData1)
- b  in  WIDTH  operand B (ALUSrc mux output)
- branch  in  1  Branch flag from main control
- alu_ctrl  out  4  registered decoded ALU operation
- result  out  WIDTH  registered ALU result
- zero  out  1  registered, 1 when result is 0
- branch_taken  out  1  registered branch AND zero

Behaviour:
- Reset: one clock and one reset, named clk and rst. Reset is synchronous and active-high and has priority over all other inputs.
  - On a rising clk edge with rst=1, alu_ctrl=0000, result=0, zero=0 and branch_taken=0.
  - zero reads 0 during reset, even though result is 0.
- Latency: inputs are sampled on each rising edge with rst=0. All outputs update together one edge later. There is no handshake; a new operation starts every cycle.
- Decode, alu_op → alu_ctrl (combinational, then registered):
  - 00 → 0010 (add; lw/sw address)
  - 01 → 0110 (sub; beq)
  - 11 → 0001 (or; ori)
  - 10 → decode funct:
    - 100000 add → 0010
    - 100010 sub → 0110
    - 100100 and → 0000
    - 100101 or → 0001
    - 101010 slt → 0111
    - 100111 nor → 1100
    - any other funct → 0010 (add)
- ALU operations, by alu_ctrl:
  - 0000: a & b
  - 0001: a | b
  - 0010: a + b, modulo 2^WIDTH; carry discarded
  - 0110: a − b, modulo 2^WIDTH
  - 0111: {WIDTH-1 zeros, (signed a < signed b)}. The comparison must be a true two's-complement compare, correct even when a−b overflows (e.g. a=0x7FFFFFFF, b=0x80000000 → 0).
  - 1100: ~(a | b)
  - Any other code (unreachable from the decoder): result = 0.
- zero = (next result == 0), computed from the same-cycle result.
- branch_taken = branch & next zero, registered in the same cycle as result. It therefore refers to the operation sampled at the same edge.
- Wrap-around: 0xFFFFFFFF + 1 → result 0, zero 1. 0 − 1 → 0xFFFFFFFF.
- Reset mid-stream: the in-flight operation is discarded. The first post-reset result appears one edge after the first edge with rst=0.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit, registered, reset 0).
  - overflow=1 when signed add (0010) or sub (0110) overflows: operand signs and result sign inconsistent per two's-complement rules.
  - overflow is 0 for all other operations.
  - result is still the wrapped value.
- Undefined: no overflow port and no detection logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 edges with a=5, b=5, alu_op=01 → all outputs 0. Release rst → next edge gives result=0, zero=1, branch_taken=branch.
- R-type sweep: a=0x0000000C, b=0x0000000A, alu_op=10, one funct per cycle:
  - add → 0x16
  - sub → 0x2
  - and → 0x8
  - or → 0xE
  - slt → 0
  - nor → 0xFFFFFFF1
  - alu_ctrl matches the decode table each cycle.
- Branch: alu_op=01, branch=1.
  - a=b=0x1234 → zero=1, branch_taken=1.
  - a=0x1234, b=0x1235 → zero=0, branch_taken=0.
  - branch=0 with a=b → branch_taken=0.
- Signed slt edges, alu_op=10, funct=101010:
  - a=0xFFFFFFFF (−1), b=1 → 1
  - a=0x7FFFFFFF, b=0x80000000 → 0
  - a=b → 0
- Wrap and default decode:
  - alu_op=00, a=0xFFFFFFFF, b=1 → result=0, zero=1
  - alu_op=10, funct=001000 → add behaviour, alu_ctrl=0010
  - alu_op=11, a=0xF0, b=0x0F → 0xFF
- With ALU_OVF_EN:
  - add 0x7FFFFFFF+1 → result 0x80000000, overflow=1
  - sub 0x80000000−1 → overflow=1
  - add 1+1 → overflow=0
